// File: rtl/regfile_arbiter_if.sv
// Requester and register-file signal bundle for regfile_arbiter.
// slave = arbiter side, master = requesters plus register file.
interface regfile_arbiter_if;
  // Handshake: every *_stb is a one-cycle request pulse. The matching *_ack is
  // a one-cycle completion pulse. A requester keeps at most one request open
  // and issues no new strobe until its ack. Operands stay stable until the ack.
  logic        rd_stb_i;
  logic [4:0]  rd_rs1_i;
  logic [4:0]  rd_rs2_i;
  logic        rd_ack_o;
  logic [31:0] rd_rs1_o;
  logic [31:0] rd_rs2_o;
  logic        wa_stb_i;
  logic [4:0]  wa_rd_i;
  logic [31:0] wa_data_i;
  logic        wa_ack_o;
  logic        wb_stb_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        wb_ack_o;
  logic        rf_stb_read_o;
  logic [4:0]  rf_op_rs1_o;
  logic [4:0]  rf_op_rs2_o;
  logic        rf_ack_read_i;
  logic [31:0] rf_reg_rs1_i;
  logic [31:0] rf_reg_rs2_i;
  logic        rf_stb_write_o;
  logic [4:0]  rf_op_rd_o;
  logic [31:0] rf_reg_rd_o;
  logic        rf_ack_write_i;

  modport slave (
    input  rd_stb_i, rd_rs1_i, rd_rs2_i, wa_stb_i, wa_rd_i, wa_data_i,
           wb_stb_i, wb_rd_i, wb_data_i, rf_ack_read_i, rf_reg_rs1_i,
           rf_reg_rs2_i, rf_ack_write_i,
    output rd_ack_o, rd_rs1_o, rd_rs2_o, wa_ack_o, wb_ack_o, rf_stb_read_o,
           rf_op_rs1_o, rf_op_rs2_o, rf_stb_write_o, rf_op_rd_o, rf_reg_rd_o
  );

  modport master (
    output rd_stb_i, rd_rs1_i, rd_rs2_i, wa_stb_i, wa_rd_i, wa_data_i,
           wb_stb_i, wb_rd_i, wb_data_i, rf_ack_read_i, rf_reg_rs1_i,
           rf_reg_rs2_i, rf_ack_write_i,
    input  rd_ack_o, rd_rs1_o, rd_rs2_o, wa_ack_o, wb_ack_o, rf_stb_read_o,
           rf_op_rs1_o, rf_op_rs2_o, rf_stb_write_o, rf_op_rd_o, rf_reg_rd_o
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Serialises one reader and two writers (A, B) onto the register-file port pair.
// Optional statistics counters are enabled with `define REGARB_STATS_EN.
module regfile_arbiter #(
  parameter int MAX_WR_BURST = 4,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_arbiter_if.slave     bus,
  output logic                 err_timeout_o,
  output logic [1:0]           state_dbg_o
`ifdef REGARB_STATS_EN
  ,
  output logic [31:0]          stat_wr_cnt_o,
  output logic [31:0]          stat_rd_cnt_o,
  output logic [31:0]          stat_stall_cnt_o
`endif
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_WR = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;
  localparam logic [1:0] SEL_RD  = 2'd0;
  localparam logic [1:0] SEL_A   = 2'd1;
  localparam logic [1:0] SEL_B   = 2'd2;
  localparam logic [3:0] BURST_MAX = 4'(MAX_WR_BURST);
  localparam logic [7:0] WD_LAST   = 8'(ACK_TIMEOUT - 1);

  logic [1:0]  state, cur_sel;
  logic        zero_wr, ptr_b;
  logic [3:0]  burst;
  logic [7:0]  wd;
  logic        rd_pend, a_pend, b_pend;
  logic [4:0]  rd_rs1_q, rd_rs2_q, a_rd_q, b_rd_q;
  logic [31:0] a_data_q, b_data_q;

  logic        done_now, timeout_now, fin, can_grant;
  logic        av_rd, av_a, av_b, grant_rd, grant_wr, pick_a;
  logic [4:0]  rs1_eff, rs2_eff, wr_idx;
  logic [31:0] wr_dat;

  assign state_dbg_o = state;

  always_comb begin
    done_now    = ((state == WAIT_WR) && (bus.rf_ack_write_i || zero_wr)) ||
                  ((state == WAIT_RD) && bus.rf_ack_read_i);
    timeout_now = (state != IDLE) && !done_now && (wd == WD_LAST);
    fin         = done_now || timeout_now;
    // A slot finishing this edge is not eligible; its own strobe is ignored.
    av_rd = (rd_pend && !(fin && cur_sel == SEL_RD)) || (bus.rd_stb_i && !rd_pend);
    av_a  = (a_pend && !(fin && cur_sel == SEL_A)) || (bus.wa_stb_i && !a_pend);
    av_b  = (b_pend && !(fin && cur_sel == SEL_B)) || (bus.wb_stb_i && !b_pend);
    rs1_eff = rd_pend ? rd_rs1_q : bus.rd_rs1_i;
    rs2_eff = rd_pend ? rd_rs2_q : bus.rd_rs2_i;
    can_grant = (state == IDLE) || done_now;
    grant_rd  = can_grant && av_rd && (!(av_a || av_b) || (burst == BURST_MAX));
    grant_wr  = can_grant && (av_a || av_b) && !grant_rd;
    pick_a    = av_a && (!av_b || !ptr_b);
    if (pick_a) begin
      wr_idx = a_pend ? a_rd_q : bus.wa_rd_i;
      wr_dat = a_pend ? a_data_q : bus.wa_data_i;
    end else begin
      wr_idx = b_pend ? b_rd_q : bus.wb_rd_i;
      wr_dat = b_pend ? b_data_q : bus.wb_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;            cur_sel <= SEL_RD;
      zero_wr <= 1'b0;          ptr_b <= 1'b0;
      burst <= '0;              wd <= '0;
      rd_pend <= 1'b0;          a_pend <= 1'b0;          b_pend <= 1'b0;
      rd_rs1_q <= '0;           rd_rs2_q <= '0;
      a_rd_q <= '0;             b_rd_q <= '0;
      a_data_q <= '0;           b_data_q <= '0;
      bus.rd_ack_o <= 1'b0;     bus.wa_ack_o <= 1'b0;    bus.wb_ack_o <= 1'b0;
      bus.rd_rs1_o <= '0;       bus.rd_rs2_o <= '0;
      bus.rf_stb_read_o <= 1'b0;  bus.rf_op_rs1_o <= '0;  bus.rf_op_rs2_o <= '0;
      bus.rf_stb_write_o <= 1'b0; bus.rf_op_rd_o <= '0;   bus.rf_reg_rd_o <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      bus.rd_ack_o <= 1'b0;
      bus.wa_ack_o <= 1'b0;
      bus.wb_ack_o <= 1'b0;
      bus.rf_stb_read_o <= 1'b0;
      bus.rf_stb_write_o <= 1'b0;
      err_timeout_o <= 1'b0;
      rd_pend <= av_rd;
      a_pend  <= av_a;
      b_pend  <= av_b;
      if (bus.rd_stb_i && !rd_pend) begin
        rd_rs1_q <= bus.rd_rs1_i;
        rd_rs2_q <= bus.rd_rs2_i;
      end
      if (bus.wa_stb_i && !a_pend) begin
        a_rd_q   <= bus.wa_rd_i;
        a_data_q <= bus.wa_data_i;
      end
      if (bus.wb_stb_i && !b_pend) begin
        b_rd_q   <= bus.wb_rd_i;
        b_data_q <= bus.wb_data_i;
      end
      wd <= ((state != IDLE) && !fin) ? wd + 8'd1 : 8'd0;
      if (done_now) begin
        state <= IDLE;
        case (cur_sel)
          SEL_A:   bus.wa_ack_o <= 1'b1;
          SEL_B:   bus.wb_ack_o <= 1'b1;
          default: begin
            bus.rd_ack_o <= 1'b1;
            bus.rd_rs1_o <= bus.rf_reg_rs1_i;
            bus.rd_rs2_o <= bus.rf_reg_rs2_i;
          end
        endcase
      end
      if (timeout_now) begin
        state <= IDLE;
        err_timeout_o <= 1'b1;
      end
      if (grant_rd) begin
        state <= WAIT_RD;
        cur_sel <= SEL_RD;
        zero_wr <= 1'b0;
        burst <= '0;
        bus.rf_stb_read_o <= 1'b1;
        bus.rf_op_rs1_o <= rs1_eff;
        bus.rf_op_rs2_o <= rs2_eff;
      end else if (grant_wr) begin
        // x0 writes never reach the regfile; they complete on the next edge.
        state <= WAIT_WR;
        cur_sel <= pick_a ? SEL_A : SEL_B;
        zero_wr <= (wr_idx == 5'd0);
        ptr_b <= pick_a;
        if (!av_rd) burst <= '0;
        else if (burst != BURST_MAX) burst <= burst + 4'd1;
        if (wr_idx != 5'd0) begin
          bus.rf_stb_write_o <= 1'b1;
          bus.rf_op_rd_o <= wr_idx;
          bus.rf_reg_rd_o <= wr_dat;
        end
      end else if (!av_rd) begin
        burst <= '0;
      end
    end
  end

`ifdef REGARB_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_wr_cnt_o <= '0;
      stat_rd_cnt_o <= '0;
      stat_stall_cnt_o <= '0;
    end else begin
      if (done_now && cur_sel != SEL_RD) stat_wr_cnt_o <= stat_wr_cnt_o + 32'd1;
      if (done_now && cur_sel == SEL_RD) stat_rd_cnt_o <= stat_rd_cnt_o + 32'd1;
      if ((rd_pend || a_pend || b_pend) && state != IDLE)
        stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a one-cycle-ack register file model.
// Also builds with REGARB_STATS_EN defined.
module tb_regfile_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic err_timeout_o;
  logic [1:0] state_dbg_o;
`ifdef REGARB_STATS_EN
  logic [31:0] stat_wr_cnt_o, stat_rd_cnt_o, stat_stall_cnt_o;
`endif

  regfile_arbiter_if bus();

  regfile_arbiter #(.MAX_WR_BURST(4), .ACK_TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .err_timeout_o(err_timeout_o), .state_dbg_o(state_dbg_o)
`ifdef REGARB_STATS_EN
    , .stat_wr_cnt_o(stat_wr_cnt_o), .stat_rd_cnt_o(stat_rd_cnt_o),
    .stat_stall_cnt_o(stat_stall_cnt_o)
`endif
  );

  // ---- clock ----
  always #5 clk_i = ~clk_i;

  // ---- register file model: acks one cycle after each strobe ----
  logic [31:0] mem [32] = '{default: 32'd0};
  logic wr_ack_en = 1'b1;
  logic rd_ack_en = 1'b1;

  always @(posedge clk_i) begin
    bus.rf_ack_write_i <= bus.rf_stb_write_o && wr_ack_en;
    bus.rf_ack_read_i  <= bus.rf_stb_read_o && rd_ack_en;
    if (bus.rf_stb_write_o) mem[bus.rf_op_rd_o] <= bus.rf_reg_rd_o;
    if (bus.rf_stb_read_o) begin
      bus.rf_reg_rs1_i <= (bus.rf_op_rs1_o == 5'd0) ? 32'd0 : mem[bus.rf_op_rs1_o];
      bus.rf_reg_rs2_i <= (bus.rf_op_rs2_o == 5'd0) ? 32'd0 : mem[bus.rf_op_rs2_o];
    end
  end

  // ---- scoreboard ----
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic clear_strobes();
    bus.rd_stb_i = 1'b0;
    bus.wa_stb_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_strobes();
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
  endtask

  initial begin : main
    int cyc, id, max_simul, nack, wr_before, cnt;
    logic rd_seen, got_err, wa_seen, wr_seen;
    logic [31:0] exp_id;
    clear_strobes();
    bus.rd_rs1_i = '0; bus.rd_rs2_i = '0;
    bus.wa_rd_i = '0;  bus.wa_data_i = '0;
    bus.wb_rd_i = '0;  bus.wb_data_i = '0;

    // reset state
    tick();
    check("rst_rf_stb_write", 32'(bus.rf_stb_write_o), 32'd0);
    check("rst_rf_stb_read", 32'(bus.rf_stb_read_o), 32'd0);
    check("rst_wa_ack", 32'(bus.wa_ack_o), 32'd0);
    check("rst_rd_rs1", bus.rd_rs1_o, 32'd0);
    check("rst_err", 32'(err_timeout_o), 32'd0);
    check("rst_state", 32'(state_dbg_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // single write then read back
    bus.wa_stb_i = 1'b1; bus.wa_rd_i = 5'd5; bus.wa_data_i = 32'hDEADBEEF;
    tick(); clear_strobes();
    check("t1_rf_stb_write", 32'(bus.rf_stb_write_o), 32'd1);
    check("t1_rf_op_rd", 32'(bus.rf_op_rd_o), 32'd5);
    check("t1_rf_reg_rd", bus.rf_reg_rd_o, 32'hDEADBEEF);
    check("t1_wa_ack_e0", 32'(bus.wa_ack_o), 32'd0);
    tick();
    check("t1_rf_stb_pulse", 32'(bus.rf_stb_write_o), 32'd0);
    check("t1_rf_op_held", 32'(bus.rf_op_rd_o), 32'd5);
    check("t1_wa_ack_e1", 32'(bus.wa_ack_o), 32'd0);
    tick();
    check("t1_wa_ack_e2", 32'(bus.wa_ack_o), 32'd1);
    tick();
    check("t1_wa_ack_pulse", 32'(bus.wa_ack_o), 32'd0);
    bus.rd_stb_i = 1'b1; bus.rd_rs1_i = 5'd5; bus.rd_rs2_i = 5'd0;
    tick(); clear_strobes();
    check("t1_rf_stb_read", 32'(bus.rf_stb_read_o), 32'd1);
    check("t1_rf_op_rs1", 32'(bus.rf_op_rs1_o), 32'd5);
    tick(); tick();
    check("t1_rd_ack", 32'(bus.rd_ack_o), 32'd1);
    check("t1_rd_rs1", bus.rd_rs1_o, 32'hDEADBEEF);
    check("t1_rd_rs2", bus.rd_rs2_o, 32'd0);

    // simultaneous A, B and read: order A, B, read
    do_reset();
    exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
    bus.wa_stb_i = 1'b1; bus.wa_rd_i = 5'd1; bus.wa_data_i = 32'h11;
    bus.wb_stb_i = 1'b1; bus.wb_rd_i = 5'd2; bus.wb_data_i = 32'h22;
    bus.rd_stb_i = 1'b1; bus.rd_rs1_i = 5'd1; bus.rd_rs2_i = 5'd2;
    tick(); clear_strobes();
    max_simul = 0; nack = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      tick();
      id = 32'(bus.wa_ack_o) + 32'(bus.wb_ack_o) + 32'(bus.rd_ack_o);
      if (id > max_simul) max_simul = id;
      nack += id;
      id = bus.wa_ack_o ? 1 : bus.wb_ack_o ? 2 : bus.rd_ack_o ? 3 : 0;
      if (id != 0) begin
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("t2_order", 32'(id), exp_id);
      end
    end
    check("t2_ack_total", 32'(nack), 32'd3);
    check("t2_distinct_cycles", 32'(max_simul), 32'd1);
    check("t2_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t2_rd_rs1", bus.rd_rs1_o, 32'h11);
    check("t2_rd_rs2", bus.rd_rs2_o, 32'h22);
`ifdef REGARB_STATS_EN
    check("t2_stat_wr", stat_wr_cnt_o, 32'd2);
    check("t2_stat_rd", stat_rd_cnt_o, 32'd1);
    check("t2_stat_stall", stat_stall_cnt_o, 32'd6);
`endif

    // starvation bound: writers re-strobe on every ack
    do_reset();
    bus.wa_stb_i = 1'b1; bus.wa_rd_i = 5'd10; bus.wa_data_i = 32'h100;
    bus.wb_stb_i = 1'b1; bus.wb_rd_i = 5'd11; bus.wb_data_i = 32'h200;
    bus.rd_stb_i = 1'b1; bus.rd_rs1_i = 5'd3; bus.rd_rs2_i = 5'd4;
    tick(); clear_strobes();
    wr_before = 0; rd_seen = 1'b0;
    for (cyc = 0; cyc < 40 && !rd_seen; cyc++) begin
      if (bus.rd_ack_o) rd_seen = 1'b1;
      else wr_before += 32'(bus.wa_ack_o) + 32'(bus.wb_ack_o);
      bus.wa_stb_i = bus.wa_ack_o; bus.wa_data_i = bus.wa_data_i + 32'd1;
      bus.wb_stb_i = bus.wb_ack_o; bus.wb_data_i = bus.wb_data_i + 32'd1;
      tick();
    end
    clear_strobes();
    check("t3_rd_granted", 32'(rd_seen), 32'd1);
    check("t3_writes_before_read", 32'(wr_before), 32'd4);
    repeat (12) tick();

    // x0 write: no regfile strobe, ack one cycle later
    do_reset();
    bus.wb_stb_i = 1'b1; bus.wb_rd_i = 5'd0; bus.wb_data_i = 32'h12345678;
    tick(); clear_strobes();
    check("t4_no_stb_e0", 32'(bus.rf_stb_write_o), 32'd0);
    check("t4_wb_ack_e0", 32'(bus.wb_ack_o), 32'd0);
    tick();
    check("t4_no_stb_e1", 32'(bus.rf_stb_write_o), 32'd0);
    check("t4_wb_ack_e1", 32'(bus.wb_ack_o), 32'd1);
    tick();
    bus.rd_stb_i = 1'b1; bus.rd_rs1_i = 5'd0; bus.rd_rs2_i = 5'd5;
    tick(); clear_strobes();
    tick(); tick();
    check("t4_rd_ack", 32'(bus.rd_ack_o), 32'd1);
    check("t4_rd_x0", bus.rd_rs1_o, 32'd0);
    check("t4_rd_x5", bus.rd_rs2_o, 32'hDEADBEEF);

    // watchdog on a read that never acks
    do_reset();
    rd_ack_en = 1'b0;
    bus.rd_stb_i = 1'b1; bus.rd_rs1_i = 5'd5; bus.rd_rs2_i = 5'd1;
    tick(); clear_strobes();
    check("t5_rf_stb_read", 32'(bus.rf_stb_read_o), 32'd1);
    cnt = 0; got_err = 1'b0; rd_seen = 1'b0;
    for (cyc = 0; cyc < 40 && !got_err; cyc++) begin
      tick();
      cnt++;
      if (bus.rd_ack_o) rd_seen = 1'b1;
      if (err_timeout_o) got_err = 1'b1;
    end
    check("t5_err_seen", 32'(got_err), 32'd1);
    check("t5_err_latency", 32'(cnt), 32'd15);
    tick();
    check("t5_err_pulse", 32'(err_timeout_o), 32'd0);
    rd_ack_en = 1'b1;
    bus.wa_stb_i = 1'b1; bus.wa_rd_i = 5'd7; bus.wa_data_i = 32'h77;
    tick(); clear_strobes();
    wa_seen = 1'b0;
    for (cyc = 0; cyc < 10; cyc++) begin
      if (bus.wa_ack_o) wa_seen = 1'b1;
      if (bus.rd_ack_o) rd_seen = 1'b1;
      tick();
    end
    check("t5_write_after_timeout", 32'(wa_seen), 32'd1);
    check("t5_no_rd_ack", 32'(rd_seen), 32'd0);

    // async reset in the middle of WAIT_WR
    do_reset();
    wr_ack_en = 1'b0;
    bus.wa_stb_i = 1'b1; bus.wa_rd_i = 5'd9; bus.wa_data_i = 32'h99;
    tick(); clear_strobes();
    check("t6_rf_stb_write", 32'(bus.rf_stb_write_o), 32'd1);
    tick();
    check("t6_state_wait_wr", 32'(state_dbg_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("t6_rf_op_rd", 32'(bus.rf_op_rd_o), 32'd0);
    check("t6_rf_reg_rd", bus.rf_reg_rd_o, 32'd0);
    check("t6_state_idle", 32'(state_dbg_o), 32'd0);
`ifdef REGARB_STATS_EN
    check("t6_stat_wr", stat_wr_cnt_o, 32'd0);
    check("t6_stat_rd", stat_rd_cnt_o, 32'd0);
    check("t6_stat_stall", stat_stall_cnt_o, 32'd0);
`endif
    wr_ack_en = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    wa_seen = 1'b0; wr_seen = 1'b0;
    for (cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (bus.wa_ack_o) wa_seen = 1'b1;
      if (bus.rf_stb_write_o) wr_seen = 1'b1;
    end
    check("t6_no_wa_ack", 32'(wa_seen), 32'd0);
    check("t6_no_rf_write", 32'(wr_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
